// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED-matrix scan capture block.
package led_scan_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;

  // One matrix row, active-high pixel bits per colour.
  typedef struct packed {
    logic [MATRIX_COLS-1:0] r;
    logic [MATRIX_COLS-1:0] g;
    logic [MATRIX_COLS-1:0] b;
  } rgb_row_t;

  // The scan bus drives columns active-low; the buffers store lit pixels as 1.
  function automatic rgb_row_t active_low_to_row(input logic [MATRIX_COLS-1:0] r_n,
                                                 input logic [MATRIX_COLS-1:0] g_n,
                                                 input logic [MATRIX_COLS-1:0] b_n);
    rgb_row_t row;
    row.r = ~r_n;
    row.g = ~g_n;
    row.b = ~b_n;
    return row;
  endfunction

endpackage

// File: rtl/led_scan_watchdog.sv
// Idle watchdog for the scan bus: counts cycles since the last accepted strobe,
// fires a one-cycle timeout pulse on reaching TIMEOUT and holds scan_lost until
// the next accepted strobe. A strobe in the firing cycle suppresses the timeout.
module led_scan_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic timeout_pulse_o,
  output logic scan_lost_o
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;
  logic          lost_q, lost_d;
  logic          timeout_pulse;

  // Next-state: strobe restarts the count, otherwise count up and saturate.
  always_comb begin
    idle_d        = idle_q;
    lost_d        = lost_q;
    timeout_pulse = 1'b0;
    if (strobe_i) begin
      idle_d = '0;
      lost_d = 1'b0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == IDLE_LAST) begin
        timeout_pulse = 1'b1;
        lost_d        = 1'b1;
      end
    end
  end

  // Idle counter and scan_lost flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q <= '0;
      lost_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      lost_q <= lost_d;
    end
  end

  assign timeout_pulse_o = timeout_pulse;
  assign scan_lost_o     = lost_q;

endmodule

// File: rtl/led_scan_frame_capture.sv
// Captures the multiplexed 8x8 RGB scan stream into a working buffer, commits
// complete frames to a snapshot buffer, and serves row reads of that snapshot.
//
// Interface timing: scan_valid is a one-cycle strobe with no back-pressure; the
// bus is sampled on the CLK edge where scan_valid=1 and is accepted only when
// COMM=1. rd_en is likewise a one-cycle request with no back-pressure; rd_valid
// follows exactly one cycle later and the rd_* data hold between reads.
module led_scan_frame_capture
  import led_scan_pkg::*;
#(
  parameter int FRAME_STROBES = 24,
  parameter int TIMEOUT       = 4096
) (
  input  logic       CLK,
  input  logic       Clear_n,
  input  logic       scan_valid,
  input  logic       COMM,
  input  logic [2:0] S,
  input  logic [7:0] DATA_R,
  input  logic [7:0] DATA_G,
  input  logic [7:0] DATA_B,
  input  logic       hold,
  input  logic       rd_en,
  input  logic [2:0] rd_row,
  output logic       rd_valid,
  output logic [7:0] rd_r,
  output logic [7:0] rd_g,
  output logic [7:0] rd_b,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic [7:0] dropped_cnt,
  output logic       overlap,
  output logic       scan_lost
);

  localparam logic [7:0] LAST_STROBE = 8'(FRAME_STROBES);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  rgb_row_t   work_q [MATRIX_ROWS];
  rgb_row_t   snap_q [MATRIX_ROWS];
  rgb_row_t   frame_d [MATRIX_ROWS];
  rgb_row_t   rd_data_q;
  logic [7:0] strobe_cnt_q;
  logic [7:0] strobe_cnt_inc;
  logic       rd_valid_q;
  logic       frame_done_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] dropped_cnt_q;
  logic       overlap_q;
  logic       frame_overlap;
  logic       strobe_ok;
  logic       commit;
  logic       timeout_pulse;

  // Reset synchroniser: assertion is immediate, release aligns to CLK.
  always_ff @(posedge CLK or negedge Clear_n) begin
    if (!Clear_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign strobe_ok      = scan_valid & COMM;
  assign strobe_cnt_inc = strobe_cnt_q + 8'd1;
  assign commit         = strobe_ok && (strobe_cnt_inc == LAST_STROBE);

  led_scan_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i           (CLK),
    .rst_ni          (rst_n),
    .strobe_i        (strobe_ok),
    .timeout_pulse_o (timeout_pulse),
    .scan_lost_o     (scan_lost)
  );

  // Working buffer with the current strobe merged in, and its G/B coincidence.
  always_comb begin
    for (int i = 0; i < MATRIX_ROWS; i++) frame_d[i] = work_q[i];
    frame_d[S] = work_q[S] | active_low_to_row(DATA_R, DATA_G, DATA_B);
    frame_overlap = 1'b0;
    for (int i = 0; i < MATRIX_ROWS; i++)
      frame_overlap = frame_overlap | (|(frame_d[i].g & frame_d[i].b));
  end

  // Working buffer and strobe counter; cleared on commit or scan timeout.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MATRIX_ROWS; i++) work_q[i] <= '0;
      strobe_cnt_q <= '0;
    end else if (commit || timeout_pulse) begin
      for (int i = 0; i < MATRIX_ROWS; i++) work_q[i] <= '0;
      strobe_cnt_q <= '0;
    end else if (strobe_ok) begin
      for (int i = 0; i < MATRIX_ROWS; i++) work_q[i] <= frame_d[i];
      strobe_cnt_q <= strobe_cnt_inc;
    end
  end

  // Snapshot commit and per-frame status; hold drops the frame instead.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MATRIX_ROWS; i++) snap_q[i] <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      dropped_cnt_q <= '0;
      overlap_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (commit) begin
        if (!hold) begin
          for (int i = 0; i < MATRIX_ROWS; i++) snap_q[i] <= frame_d[i];
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 8'd1;
          overlap_q    <= frame_overlap;
        end else if (dropped_cnt_q != 8'hFF) begin
          dropped_cnt_q <= dropped_cnt_q + 8'd1;
        end
      end
    end
  end

  // Registered snapshot readback; sees the snapshot as it was before the edge.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= snap_q[rd_row];
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_r        = rd_data_q.r;
  assign rd_g        = rd_data_q.g;
  assign rd_b        = rd_data_q.b;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign dropped_cnt = dropped_cnt_q;
  assign overlap     = overlap_q;

endmodule

// File: tb/tb_led_scan_frame_capture.sv
// Directed bench for led_scan_frame_capture with hand-computed expectations.
module tb_led_scan_frame_capture;

  localparam int FRAME_STROBES = 24;
  localparam int TIMEOUT       = 4096;

  logic       CLK = 1'b0;
  logic       Clear_n = 1'b0;
  logic       scan_valid = 1'b0;
  logic       COMM = 1'b0;
  logic [2:0] S = 3'd0;
  logic [7:0] DATA_R = 8'hFF;
  logic [7:0] DATA_G = 8'hFF;
  logic [7:0] DATA_B = 8'hFF;
  logic       hold = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_row = 3'd0;
  logic       rd_valid;
  logic [7:0] rd_r, rd_g, rd_b;
  logic       frame_done;
  logic [7:0] frame_cnt, dropped_cnt;
  logic       overlap, scan_lost;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [7:0] exp_q[$];

  led_scan_frame_capture #(.FRAME_STROBES(FRAME_STROBES), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Clear_n(Clear_n), .scan_valid(scan_valid), .COMM(COMM), .S(S),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B), .hold(hold),
    .rd_en(rd_en), .rd_row(rd_row), .rd_valid(rd_valid), .rd_r(rd_r), .rd_g(rd_g),
    .rd_b(rd_b), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .dropped_cnt(dropped_cnt), .overlap(overlap), .scan_lost(scan_lost)
  );

  // Clock and frame_done pulse monitor (counts pulses seen before each edge).
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (frame_done) done_seen++;

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic do_reset();
    Clear_n = 1'b0;
    scan_valid = 1'b0; COMM = 1'b0; hold = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge CLK);
    Clear_n = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_strobe(input logic [2:0] row, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b, input logic comm);
    scan_valid = 1'b1; COMM = comm; S = row;
    DATA_R = r; DATA_G = g; DATA_B = b;
    @(negedge CLK);
    scan_valid = 1'b0; COMM = 1'b0;
    DATA_R = 8'hFF; DATA_G = 8'hFF; DATA_B = 8'hFF;
  endtask

  task automatic send_plain(input int n, input logic comm);
    for (int i = 0; i < n; i++) drive_strobe(3'(i % 8), 8'hFF, 8'hFF, 8'hFF, comm);
  endtask

  task automatic read_row(input logic [2:0] row, output logic [7:0] r,
                          output logic [7:0] g, output logic [7:0] b, output logic v);
    rd_en = 1'b1; rd_row = row;
    @(negedge CLK);
    rd_en = 1'b0;
    v = rd_valid; r = rd_r; g = rd_g; b = rd_b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %h exp 00", frame_cnt); end
    checks++; if (dropped_cnt !== 8'd0) begin errors++; $display("FAIL reset_dropped got %h exp 00", dropped_cnt); end
    checks++; if ({rd_valid, frame_done, overlap, scan_lost} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {rd_valid, frame_done, overlap, scan_lost}); end
    checks++; if ({rd_r, rd_g, rd_b} !== 24'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 000000", {rd_r, rd_g, rd_b}); end
  endtask

  task automatic test_basic_frame();
    int d0;
    logic [7:0] r, g, b;
    logic v;
    d0 = done_seen;
    drive_strobe(3'd7, 8'hFF, 8'hFF, 8'h7F, 1'b1);
    send_plain(FRAME_STROBES - 1, 1'b1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got %b exp 1", frame_done); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_frame_cnt got %h exp 01", frame_cnt); end
    idle_cycles(1);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got %b exp 0", frame_done); end
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_seen - d0); end
    for (int row = 0; row < 8; row++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(row == 7 ? 8'h80 : 8'h00);
    end
    for (int row = 0; row < 8; row++) begin
      logic [7:0] er, eg, eb;
      read_row(3'(row), r, g, b, v);
      er = exp_q.pop_front(); eg = exp_q.pop_front(); eb = exp_q.pop_front();
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL basic_rd_valid row %0d got %b exp 1", row, v); end
      checks++; if ({r, g, b} !== {er, eg, eb}) begin errors++; $display("FAIL basic_rd_row row %0d got %h exp %h", row, {r, g, b}, {er, eg, eb}); end
    end
    idle_cycles(1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_valid_idle got %b exp 0", rd_valid); end
    checks++; if (rd_b !== 8'h80) begin errors++; $display("FAIL basic_rd_hold got %h exp 80", rd_b); end
  endtask

  task automatic test_overlap();
    logic [7:0] r, g, b;
    logic v;
    drive_strobe(3'd3, 8'hFF, 8'hEF, 8'hFF, 1'b1);
    drive_strobe(3'd3, 8'hFF, 8'hFF, 8'hEF, 1'b1);
    send_plain(FRAME_STROBES - 2, 1'b1);
    checks++; if (overlap !== 1'b1) begin errors++; $display("FAIL overlap_set got %b exp 1", overlap); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL overlap_cnt1 got %h exp 02", frame_cnt); end
    drive_strobe(3'd3, 8'hFF, 8'hEF, 8'hFF, 1'b1);
    send_plain(FRAME_STROBES - 1, 1'b1);
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL overlap_clear got %b exp 0", overlap); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL overlap_cnt2 got %h exp 03", frame_cnt); end
    read_row(3'd3, r, g, b, v);
    checks++; if ({r, g, b} !== 24'h001000) begin errors++; $display("FAIL overlap_row3 got %h exp 001000", {r, g, b}); end
  endtask

  task automatic test_comm_gate();
    int d0;
    do_reset();
    d0 = done_seen;
    send_plain(FRAME_STROBES, 1'b0);
    idle_cycles(2);
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL comm0_frame_cnt got %h exp 00", frame_cnt); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL comm0_done got %0d exp 0", done_seen - d0); end
    send_plain(FRAME_STROBES, 1'b1);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL comm1_frame_cnt got %h exp 01", frame_cnt); end
  endtask

  task automatic test_hold();
    int d0;
    logic [7:0] r, g, b;
    logic v;
    drive_strobe(3'd5, 8'hF0, 8'hFF, 8'hFF, 1'b1);
    send_plain(FRAME_STROBES - 1, 1'b1);
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL hold_pre_cnt got %h exp 02", frame_cnt); end
    hold = 1'b1;
    idle_cycles(1);
    d0 = done_seen;
    for (int f = 0; f < 3; f++) begin
      drive_strobe(3'd5, 8'hFF, 8'hFF, 8'h00, 1'b1);
      send_plain(FRAME_STROBES - 1, 1'b1);
    end
    idle_cycles(1);
    checks++; if (dropped_cnt !== 8'd3) begin errors++; $display("FAIL hold_dropped got %h exp 03", dropped_cnt); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL hold_frame_cnt got %h exp 02", frame_cnt); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL hold_done got %0d exp 0", done_seen - d0); end
    read_row(3'd5, r, g, b, v);
    checks++; if ({r, g, b} !== 24'h0F0000) begin errors++; $display("FAIL hold_snapshot got %h exp 0F0000", {r, g, b}); end
    hold = 1'b0;
    drive_strobe(3'd5, 8'hFF, 8'h00, 8'hFF, 1'b1);
    send_plain(FRAME_STROBES - 1, 1'b1);
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL hold_release_cnt got %h exp 03", frame_cnt); end
    read_row(3'd5, r, g, b, v);
    checks++; if ({r, g, b} !== 24'h00FF00) begin errors++; $display("FAIL hold_release_row got %h exp 00FF00", {r, g, b}); end
  endtask

  task automatic test_timeout();
    int d0;
    logic [7:0] r, g, b;
    logic v;
    drive_strobe(3'd2, 8'h00, 8'hFF, 8'hFF, 1'b1);
    send_plain(9, 1'b1);
    idle_cycles(TIMEOUT - 1);
    checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", scan_lost); end
    idle_cycles(1);
    checks++; if (scan_lost !== 1'b1) begin errors++; $display("FAIL timeout_lost got %b exp 1", scan_lost); end
    d0 = done_seen;
    drive_strobe(3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", scan_lost); end
    send_plain(FRAME_STROBES - 1, 1'b1);
    idle_cycles(1);
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL timeout_done_count got %0d exp 1", done_seen - d0); end
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL timeout_frame_cnt got %h exp 04", frame_cnt); end
    read_row(3'd2, r, g, b, v);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL timeout_discard got %h exp 00", r); end
  endtask

  task automatic test_read_on_commit();
    logic [7:0] r, g, b;
    logic v;
    drive_strobe(3'd4, 8'h00, 8'hFF, 8'hFF, 1'b1);
    send_plain(FRAME_STROBES - 2, 1'b1);
    scan_valid = 1'b1; COMM = 1'b1; S = 3'd0;
    rd_en = 1'b1; rd_row = 3'd4;
    @(negedge CLK);
    scan_valid = 1'b0; COMM = 1'b0; rd_en = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL roc_done got %b exp 1", frame_done); end
    checks++; if ({rd_valid, rd_r} !== {1'b1, 8'h00}) begin errors++; $display("FAIL roc_old_row got %b/%h exp 1/00", rd_valid, rd_r); end
    read_row(3'd4, r, g, b, v);
    checks++; if ({v, r} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL roc_new_row got %b/%h exp 1/FF", v, r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r, g, b;
    logic v;
    send_plain(5, 1'b1);
    #2 Clear_n = 1'b0;
    #1;
    checks++; if ({frame_cnt, dropped_cnt} !== 16'h0) begin errors++; $display("FAIL midrst_counts got %h exp 0000", {frame_cnt, dropped_cnt}); end
    checks++; if ({rd_r, rd_g, rd_b} !== 24'h0) begin errors++; $display("FAIL midrst_rd_data got %h exp 000000", {rd_r, rd_g, rd_b}); end
    checks++; if ({rd_valid, frame_done, overlap, scan_lost} !== 4'b0) begin errors++; $display("FAIL midrst_flags got %b exp 0000", {rd_valid, frame_done, overlap, scan_lost}); end
    @(negedge CLK);
    Clear_n = 1'b1;
    idle_cycles(4);
    read_row(3'd4, r, g, b, v);
    checks++; if ({v, r} !== {1'b1, 8'h00}) begin errors++; $display("FAIL midrst_snapshot got %b/%h exp 1/00", v, r); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    test_basic_frame();
    test_overlap();
    test_comm_gate();
    test_hold();
    test_timeout();
    test_read_on_commit();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL bench_timeout got running exp finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/led_scan_frame_capture.md
Name: led_scan_frame_capture

Overview:
- Sink for the 8x8 RGB LED-matrix scan bus driven by the game display logic: DATA_R/G/B are active-low column data, S is the 3-bit row select and COMM is the common enable.
- Samples that multiplexed stream and reassembles a full frame.
- Commits each complete frame to a readable snapshot buffer and reports per-frame status (frame count, green/blue overlap, scan loss).
- Consumers are the self-check/scoreboard logic and the on-board debug readback.

Parameters:
- FRAME_STROBES, 24, number of accepted scan strobes per frame (8 rows x 3 colour slots); legal range 1..255.
- TIMEOUT, 4096, CLK cycles without an accepted strobe before scan_lost asserts; legal range >= 2.

Ports:
- CLK  in  1  system clock
- Clear_n  in  1  asynchronous active-low reset
- scan_valid  in  1  one-cycle strobe: the scan bus is stable and is sampled this cycle
- COMM  in  1  display common enable; a strobe is accepted only when COMM=1
- S  in  3  row select of the current scan slot
- DATA_R  in  8  red column data, active-low
- DATA_G  in  8  green column data, active-low
- DATA_B  in  8  blue column data, active-low
- hold  in  1  1 = freeze the snapshot buffer; completed frames are dropped
- rd_en  in  1  read request for row rd_row
- rd_row  in  3  snapshot row to read
- rd_valid  out  1  read data valid, one cycle after rd_en
- rd_r  out  8  snapshot red row, active-high
- rd_g  out  8  snapshot green row, active-high
- rd_b  out  8  snapshot blue row, active-high
- frame_done  out  1  one-cycle pulse when a frame is committed
- frame_cnt  out  8  number of committed frames, wraps 255->0
- dropped_cnt  out  8  frames completed while hold=1, saturates at 255
- overlap  out  1  last committed frame had at least one pixel lit in both G and B
- scan_lost  out  1  no accepted strobe for TIMEOUT cycles

Behaviour:
- Reset (async assert, synchronous release) clears:
  - working and snapshot buffers to 0
  - strobe counter and idle counter to 0
  - all outputs to 0
- Accepted strobe: scan_valid=1 and COMM=1.
  - Working row S |= ~DATA_R, ~DATA_G, ~DATA_B, OR-accumulated per colour.
  - Strobe counter increments.
  - Strobes with COMM=0 are ignored entirely: not counted, and they do not reset the idle counter.
- Commit, on the accepted strobe that makes the counter reach FRAME_STROBES:
  - That strobe's data is included in the frame.
  - Next cycle, the working buffer including this strobe is visible in the snapshot, frame_done=1 for one cycle, frame_cnt+1, overlap updates.
  - In the same edge, the working buffer clears and the counter returns to 0.
  - A strobe in the cycle after the commit starts the new frame normally.
- hold=1 at commit:
  - Snapshot, frame_cnt and overlap are unchanged; no frame_done.
  - dropped_cnt saturating +1.
  - Working buffer still clears.
- Read: rd_en sampled at CLK.
  - Next cycle rd_valid=1 and rd_r/g/b = snapshot[rd_row] as it was before that edge.
  - A read issued on the commit cycle returns old data.
  - Back-to-back reads are supported, one per cycle; rd_valid=0 otherwise, and rd data holds its last value.
- Watchdog:
  - Idle counter resets on every accepted strobe and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: scan_lost=1, the working buffer and strobe counter are cleared (partial frame discarded), and the snapshot is kept.
  - scan_lost clears on the next accepted strobe, which is the first strobe of a fresh frame.
  - If a strobe arrives in the same cycle the timeout would fire, the strobe wins and no timeout occurs.
- Widths:
  - Strobe counter is 8 bits; idle counter is $clog2(TIMEOUT+1) bits.
  - Row OR accumulates; there is no arithmetic on pixel data.
- Only synchronous logic on CLK; no derived clocks.

Decomposition:
- Package led_scan_pkg:
  - MATRIX_ROWS=8 and MATRIX_COLS=8.
  - typedef rgb_row_t as a packed struct {r,g,b} of 8 bits each.
  - function active_low_to_row().
- Sub-module led_scan_watchdog:
  - Contains the idle counter, TIMEOUT compare, strobe-wins priority and the scan_lost flag.
  - Output: timeout_pulse, which triggers the working-buffer clear.

Test Plan:
- Reset, then FRAME_STROBES=24 strobes with COMM=1 where row 7 gets DATA_B=8'h7F once and everything else is 8'hFF -> frame_done pulses once, frame_cnt=1, a read of row 7 gives rd_b=8'h80 with rd_valid one cycle after rd_en, and all other rows read 0.
- Row 3 strobed with DATA_G=8'hEF and then DATA_B=8'hEF in one frame -> overlap=1; the next frame without that coincidence -> overlap=0.
- 24 strobes with COMM=0 -> no frame_done and frame_cnt stays 0; then 24 valid strobes -> frame_cnt=1.
- hold=1 across 3 complete frames -> dropped_cnt=3 and the snapshot is unchanged; release hold, then one frame -> frame_cnt+1 with the new data.
- 10 strobes, then a TIMEOUT-cycle gap -> scan_lost=1 and the partial frame is discarded; the next 24 strobes give exactly one frame_done, and scan_lost clears on the first of them.
- rd_en on the commit cycle -> returns the pre-commit row; rd_en the following cycle -> returns the new row. Assert Clear_n mid-frame -> all outputs 0 immediately.
